rf_writeback_arbiter: RTL
=========================

Name: rf_writeback_arbiter

Overview:
Write-side master for the rv32 IEU 3-port register file. It merges writeback results from three producers into the single sequential write port (we3/wa3/wd3): the single-cycle ALU, the load/store unit (LSU) and the mul/div unit. It also keeps a pending-register scoreboard that decode uses to stall on long-latency destinations.

Parameters:
WORD_LENGTH, 32, data width of every writeback port and of wd3
ADDR_LENGTH, 5, register address width; number of registers is 2**ADDR_LENGTH

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
alu_valid  in  1  ALU result present this cycle; cannot be stalled
alu_rd  in  ADDR_LENGTH  ALU destination register
alu_wd  in  WORD_LENGTH  ALU result
lsu_valid  in  1  LSU load result request
lsu_ready  out  1  LSU result accepted this cycle
lsu_rd  in  ADDR_LENGTH  LSU destination register
lsu_wd  in  WORD_LENGTH  LSU load data
md_valid  in  1  mul/div result request
md_ready  out  1  mul/div result accepted this cycle
md_rd  in  ADDR_LENGTH  mul/div destination register
md_wd  in  WORD_LENGTH  mul/div result
issue_valid  in  1  a long-latency op (load/mul/div) issues this cycle
issue_rd  in  ADDR_LENGTH  destination register of the issuing op
pending  out  2**ADDR_LENGTH  scoreboard; bit r=1 means r awaits a long-latency write
dup_issue_err  out  1  sticky; issue to an already-pending register
we3  out  1  register file write enable (registered)
wa3  out  ADDR_LENGTH  register file write address (registered)
wd3  out  WORD_LENGTH  register file write data (registered)

Behaviour:
- Reset (rst_n low, asynchronous): we3=0, wa3=0, wd3=0, pending=0, dup_issue_err=0, round-robin pointer=LSU, long-write flag=0.
- Grant is combinational each cycle:
  - alu_valid=1: ALU wins; lsu_ready=0 and md_ready=0.
  - Otherwise, if only one of LSU/MD is valid, that one gets ready=1.
  - If both are valid, the round-robin pointer chooses. The pointer flips to the other source only after a contested grant.
- A handshake (valid & ready) or alu_valid registers the result on the next edge: we3=1, wa3=rd, wd3=data. Latency is 1 cycle from the handshake to we3 high. The register file captures the data one edge after that.
- With no grant, we3=0 on the next edge. wa3/wd3 hold their previous values.
- rd==0 from any source: the request is accepted (ready as normal) but we3 is forced to 0. x0 is never written.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets pending[issue_rd] at the edge.
  - pending[r] clears at the edge on which the register file captures a long-latency write to r, i.e. when we3=1, wa3=r and the registered source is LSU or MD.
  - A register therefore never reads pending=0 while its regfile contents are stale.
  - Set and clear of the same r on the same edge: set wins.
  - ALU writes never touch pending.
  - issue_valid to r with pending[r]=1: dup_issue_err sets and stays set until reset; pending[r] stays 1.
- Producers must hold valid/rd/wd stable until ready. Dropping valid before ready is a protocol error and its behaviour is unspecified.
- A long-latency source can starve while the ALU is valid every cycle. Bounding that is the issue logic's job, not this block's.

Optional Feature:
- Macro: RF_WB_STALL_CNT_EN.
- When defined, adds output stall_cnt (32 bits) that counts cycles where lsu_valid|md_valid=1 and no long-latency handshake occurs. It resets to 0 and saturates at all-ones.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package rv32_wb_pkg holds:
  - wb_src_e enum {WB_NONE, WB_ALU, WB_LSU, WB_MD}
  - the WORD_LENGTH/ADDR_LENGTH defaults
  - wb_req_t struct {valid, rd, wd}
- One sub-module, rf_scoreboard, holds the pending vector with set/clear/dup-error logic. The arbiter and output registers stay in the top.

Test Plan:
- Reset mid-write: with we3=1, assert rst_n=0 asynchronously -> we3, pending and dup_issue_err go to 0 immediately, without waiting for a clock.
- ALU priority: alu_valid, lsu_valid, md_valid all 1 with alu_rd=3, alu_wd=0x11 -> lsu_ready=md_ready=0; next edge we3=1, wa3=3, wd3=0x11; LSU and MD still pending.
- Round-robin: LSU(rd=5, 0xAA) and MD(rd=6, 0xBB) held valid with no ALU -> successive writes are LSU then MD.
- Scoreboard: issue rd=7; two cycles later LSU writes rd=7 -> pending[7]=1 until the edge after we3=1, wa3=7; simultaneous reissue of rd=7 on that edge keeps pending[7]=1.
- x0 and duplicate issue: LSU rd=0 valid -> lsu_ready=1, we3 stays 0. Issue rd=9 twice with no write between -> dup_issue_err=1, sticky until reset.
- Starvation with RF_WB_STALL_CNT_EN: ALU valid for 10 cycles while LSU valid -> stall_cnt=10.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// Shared writeback types for the rv32 IEU register-file write side.
package rv32_wb_pkg;

    localparam int WB_WORD_LENGTH = 32;
    localparam int WB_ADDR_LENGTH = 5;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU, WB_MD} wb_src_e;

    typedef struct packed {
        logic                      valid;
        logic [WB_ADDR_LENGTH-1:0] rd;
        logic [WB_WORD_LENGTH-1:0] wd;
    } wb_req_t;

    function automatic logic is_long_src(input wb_src_e src);
        return (src == WB_LSU) || (src == WB_MD);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: set on long-latency issue, clear when the
// register file captures the matching long-latency write.
module rf_scoreboard #(
    parameter int ADDR_LENGTH = 5,
    parameter int NREG        = 2**ADDR_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_valid_i,
    input  logic [ADDR_LENGTH-1:0] set_rd_i,
    input  logic                   clr_valid_i,
    input  logic [ADDR_LENGTH-1:0] clr_rd_i,
    output logic [NREG-1:0]        pending_o,
    output logic                   dup_err_o
);

    logic [NREG-1:0] pending_q, pending_d;
    logic            dup_q, dup_d;
    logic            set_live;

    assign set_live = set_valid_i && (set_rd_i != '0);

    always_comb begin
        pending_d = pending_q;
        // Clear first so a same-edge reissue of the register keeps it pending.
        if (clr_valid_i) pending_d[clr_rd_i] = 1'b0;
        if (set_live)    pending_d[set_rd_i] = 1'b1;
        dup_d = dup_q | (set_live && pending_q[set_rd_i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            dup_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dup_q     <= dup_d;
        end
    end

    assign pending_o = pending_q;
    assign dup_err_o = dup_q;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU/LSU/MD writebacks into the single registered regfile write port.
// Optional RF_WB_STALL_CNT_EN adds a saturating long-latency stall counter.
module rf_writeback_arbiter
    import rv32_wb_pkg::*;
#(
    parameter int WORD_LENGTH = WB_WORD_LENGTH,
    parameter int ADDR_LENGTH = WB_ADDR_LENGTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [ADDR_LENGTH-1:0]    alu_rd,
    input  logic [WORD_LENGTH-1:0]    alu_wd,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [ADDR_LENGTH-1:0]    lsu_rd,
    input  logic [WORD_LENGTH-1:0]    lsu_wd,
    input  logic                      md_valid,
    output logic                      md_ready,
    input  logic [ADDR_LENGTH-1:0]    md_rd,
    input  logic [WORD_LENGTH-1:0]    md_wd,
    input  logic                      issue_valid,
    input  logic [ADDR_LENGTH-1:0]    issue_rd,
    output logic [2**ADDR_LENGTH-1:0] pending,
    output logic                      dup_issue_err,
`ifdef RF_WB_STALL_CNT_EN
    output logic [31:0]               stall_cnt,
`endif
    output logic                      we3,
    output logic [ADDR_LENGTH-1:0]    wa3,
    output logic [WORD_LENGTH-1:0]    wd3
);

    wb_req_t alu_req, lsu_req, md_req, sel_req;
    wb_src_e sel_src;
    logic    contested;
    logic    rr_lsu_q, rr_lsu_d;
    logic    we3_q, we3_d;
    logic    long_q, long_d;
    logic [ADDR_LENGTH-1:0] wa3_q, wa3_d;
    logic [WORD_LENGTH-1:0] wd3_q, wd3_d;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, wd: alu_wd};
    assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, wd: lsu_wd};
    assign md_req  = '{valid: md_valid,  rd: md_rd,  wd: md_wd};

    always_comb begin
        lsu_ready = 1'b0;
        md_ready  = 1'b0;
        sel_src   = WB_NONE;
        sel_req   = '0;
        if (alu_valid) begin
            sel_src = WB_ALU;
            sel_req = alu_req;
        end else if (lsu_valid && (!md_valid || rr_lsu_q)) begin
            lsu_ready = 1'b1;
            sel_src   = WB_LSU;
            sel_req   = lsu_req;
        end else if (md_valid) begin
            md_ready = 1'b1;
            sel_src  = WB_MD;
            sel_req  = md_req;
        end
    end

    // Pointer only moves after a grant that actually had to choose.
    assign contested = !alu_valid && lsu_valid && md_valid;
    assign rr_lsu_d  = contested ? ~rr_lsu_q : rr_lsu_q;

    always_comb begin
        we3_d  = sel_req.valid && (sel_req.rd != '0);
        long_d = is_long_src(sel_src);
        wa3_d  = wa3_q;
        wd3_d  = wd3_q;
        if (sel_src != WB_NONE) begin
            wa3_d = sel_req.rd;
            wd3_d = sel_req.wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
            long_q   <= 1'b0;
            rr_lsu_q <= 1'b1;
        end else begin
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            long_q   <= long_d;
            rr_lsu_q <= rr_lsu_d;
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

    // The regfile captures on the edge after we3 rises; clear pending then.
    rf_scoreboard #(
        .ADDR_LENGTH (ADDR_LENGTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (issue_valid),
        .set_rd_i    (issue_rd),
        .clr_valid_i (we3_q && long_q),
        .clr_rd_i    (wa3_q),
        .pending_o   (pending),
        .dup_err_o   (dup_issue_err)
    );

`ifdef RF_WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        long_wait;

    assign long_wait = (lsu_valid || md_valid) && !lsu_ready && !md_ready;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (long_wait && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
